regfile_decoded: RTL and testbench

- Parametrised register file: successor to the fixed 5-to-32 write-address decoder.
- Generalises the decoder to 2**ADDR_W registers and adds storage, two read ports and a hardwired zero register.
- Adds a sequenced bulk-clear engine with busy/drop signalling.
- Sits in the CPU datapath between decode and execute stages.

---
 rtl/regfile_decoded.sv | 146 ++++++++++++++
 tb/tb_regfile_decoded.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_decoded.sv
// Parametrised register file: one-hot write decode, two async read ports, sequenced bulk clear.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_decoded #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  input  logic              ClrReq,
  output logic              Busy,
  output logic              WrDrop
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS-1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wrdrop_q, wrdrop_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic                zero_hit;
  logic                wr_ok;
  logic                clr_en;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] we;

  // Hardwired zero register swallows writes without counting them as drops.
  assign zero_hit = (ZERO_REG != 0) && (Awr == '0);
  assign wr_ok    = WrEn && (state_q == IDLE)
                  && !ClrReq && !zero_hit;

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = (Awr == ADDR_W'(i));
    end
  end

  assign we = wr_ok ? dec : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ClrReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wrdrop_d = WrEn && (busy_q || ClrReq);

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we[i]) begin
        regs_d[i] = Din;
      end
      if (clr_en && (ptr_q == ADDR_W'(i))) begin
        regs_d[i] = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      wrdrop_q <= 1'b0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      wrdrop_q <= wrdrop_d;
      regs_q   <= regs_d;
    end
  end

  // wr_ok already excludes CLEAR and the zero register, so forwarding inherits both.
  always_comb begin
    Dout1 = regs_q[Ard1];
    if ((ZERO_REG != 0) && (Ard1 == '0)) begin
      Dout1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (Ard1 == Awr)) begin
      Dout1 = Din;
    end
`endif
  end

  always_comb begin
    Dout2 = regs_q[Ard2];
    if ((ZERO_REG != 0) && (Ard2 == '0)) begin
      Dout2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (Ard2 == Awr)) begin
      Dout2 = Din;
    end
`endif
  end

  assign Busy   = busy_q;
  assign WrDrop = wrdrop_q;

endmodule

// File: tb/tb_regfile_decoded.sv
// Scoreboard bench for regfile_decoded (default parameters).
// Forwarding expectations follow REGFILE_BYPASS_EN.
module tb_regfile_decoded;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  Ard1 = '0;
  logic [4:0]  Ard2 = '0;
  logic [31:0] Dout1;
  logic [31:0] Dout2;
  logic [4:0]  Awr = '0;
  logic [31:0] Din = '0;
  logic        WrEn = 1'b0;
  logic        ClrReq = 1'b0;
  logic        Busy;
  logic        WrDrop;

  regfile_decoded dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Ard1   (Ard1),
    .Ard2   (Ard2),
    .Dout1  (Dout1),
    .Dout2  (Dout2),
    .Awr    (Awr),
    .Din    (Din),
    .WrEn   (WrEn),
    .ClrReq (ClrReq),
    .Busy   (Busy),
    .WrDrop (WrDrop)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2,
                    input string tag);
    sb_t e;
    sb_q.push_back('{tag: {tag, "_d1"}, exp: e1});
    sb_q.push_back('{tag: {tag, "_d2"}, exp: e2});
    Ard1 = a1;
    Ard2 = a2;
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, Dout1, e.exp);
    e = sb_q.pop_front();
    check_eq(e.tag, Dout2, e.exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    Awr  = a;
    Din  = d;
    WrEn = 1'b1;
    tick();
    WrEn = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic fill();
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
  endtask

  // Runs one clear; returns the number of cycles Busy was seen high.
  task automatic clr_run(input bit sim, input bit mid,
                         input int wr_k, input int re_k,
                         input int rst_k, output int cnt);
    ClrReq = 1'b1;
    if (sim) begin
      WrEn = 1'b1;
      Awr  = 5'd3;
      Din  = 32'h5555_0003;
    end
    tick();
    ClrReq = 1'b0;
    WrEn   = 1'b0;
    if (sim) check_eq("sim_wrdrop", 32'(WrDrop), 32'd1);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (!Busy) break;
      cnt++;
      if (mid && k == 10) begin
        rd(5'd9, 5'd20, 32'h0, 32'h114, "mid_a");
        rd(5'd10, 5'd31, 32'h10A, 32'h11F, "mid_b");
      end
      if (k == rst_k) begin
        Rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_wrdrop", 32'(WrDrop), 32'd0);
        rd(5'd16, 5'd31, 32'h0, 32'h0, "rst_a");
        rd(5'd20, 5'd25, 32'h0, 32'h0, "rst_b");
        break;
      end
      if (k == wr_k) begin
        WrEn = 1'b1;
        Awr  = 5'd7;
        Din  = 32'hAAAA_5555;
      end
      if (k == re_k) ClrReq = 1'b1;
      tick();
      ClrReq = 1'b0;
      if (k == wr_k) begin
        WrEn = 1'b0;
        check_eq("busy_wrdrop", 32'(WrDrop), 32'd1);
      end
    end
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    #3;
    check_eq("reset_busy", 32'(Busy), 32'd0);
    check_eq("reset_wrdrop", 32'(WrDrop), 32'd0);
    rd(5'd5, 5'd31, 32'h0, 32'h0, "reset_rd");
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    rd(5'd5, 5'd31, 32'hDEAD_BEEF, 32'h1234_5678, "basic");
    rd(5'd1, 5'd30, 32'h0, 32'h0, "basic_other");
    rd(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "same_addr");

    wr(5'd0, 32'hFFFF_FFFF);
    check_eq("zero_wrdrop", 32'(WrDrop), 32'd0);
    rd(5'd0, 5'd0, 32'h0, 32'h0, "zero_rd");

    fill();
    rd(5'd0, 5'd17, model[0], model[17], "fill_a");
    rd(5'd1, 5'd31, model[1], model[31], "fill_b");
    clr_run(1'b0, 1'b1, -1, -1, -1, cnt);
    check_eq("busy_len1", 32'(cnt), 32'd32);
    check_eq("idle_wrdrop", 32'(WrDrop), 32'd0);
    for (int i = 0; i < 32; i += 2)
      rd(5'(i), 5'(i + 1), model[i], model[i + 1], "after_clr");

    fill();
    clr_run(1'b0, 1'b0, 10, 20, -1, cnt);
    check_eq("busy_len2", 32'(cnt), 32'd32);
    rd(5'd7, 5'd20, 32'h0, 32'h0, "drop_rd");

    fill();
    clr_run(1'b1, 1'b0, -1, -1, 15, cnt);
    check_eq("rst_cnt", 32'(cnt), 32'd16);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(Busy), 32'd0);
    rd(5'd31, 5'd18, 32'h0, 32'h0, "post_rst");

    wr(5'd12, 32'h1111_2222);
    Awr  = 5'd12;
    Din  = 32'hCAFE_F00D;
    WrEn = 1'b1;
`ifdef REGFILE_BYPASS_EN
    rd(5'd12, 5'd0, 32'hCAFE_F00D, 32'h0, "byp_pre");
`else
    rd(5'd12, 5'd0, 32'h1111_2222, 32'h0, "byp_pre");
`endif
    tick();
    WrEn = 1'b0;
    model[12] = 32'hCAFE_F00D;
    rd(5'd12, 5'd12, model[12], model[12], "byp_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
